pipe_seq_ctrl: RTL and testbench
================================

# pipe_seq_ctrl

Pipeline sequencing controller for the five-stage WISC core. It owns every pipeline-register write enable and bubble control, and it owns the PC write enable. It resolves load-use hazards, EX-stage branch/jump flushes, instruction- and data-memory stalls, and halt. It sits beside the execution stage and consumes that stage's `flush`/`next_pc` outputs. It keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `STALL_CNT_W`, 16, width of the stall-cycle counter.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ifid_instr`  in  16  instruction currently in ID.
- `idex_mem_read`  in  1  instruction in EX is a load (LD).
- `idex_dst_reg`  in  3  destination register of the instruction in EX.
- `ex_flush`  in  1  EX resolved a taken branch or a jump.
- `ex_next_pc`  in  16  redirect target from EX.
- `imem_stall`  in  1  instruction memory busy; the fetched word is invalid.
- `imem_done`  in  1  instruction memory finished the outstanding access.
- `dmem_stall`  in  1  data memory busy on the instruction in MEM.
- `dmem_done`  in  1  data memory finished the outstanding access.
- `memwb_halt`  in  1  HALT is in the MEM/WB register.
- `pc_write`  out  1  PC register enable.
- `pc_redirect`  out  1  PC loads `pc_redirect_addr` instead of PC+2.
- `pc_redirect_addr`  out  16  redirect target.
- `ifid_write`, `idex_write`, `exmem_write`, `memwb_write`  out  1 each  pipeline-register enables.
- `ifid_flush`  out  1  load a NOP into IF/ID.
- `idex_bubble`  out  1  load a NOP (all control signals zero) into ID/EX.
- `halted`  out  1  core stopped.
- `stall_count`  out  STALL_CNT_W  saturating count of cycles with `pc_write`=0 while not halted.

## Operation
- **States:**
  - RUN
  - DWAIT (data-memory freeze)
  - IWAIT (fetch pending with a redirect held)
  - HALTED
- **Registers:**
  - `state`
  - `pend_valid`
  - `pend_addr[15:0]`
  - `stall_count`
- **Load-use hazard (`lu`):** `idex_mem_read` AND (rs match OR rt match).
  - rs match: `ifid_instr[10:8]==idex_dst_reg`. Applies to all opcodes except 00000, 00001, 00010, 00011, 00100, 00110, 11000.
  - rt match: `ifid_instr[7:5]==idex_dst_reg`. Applies only to opcodes 10000, 10011, 11010, 11011, 111xx.
- **Default outputs:** all writes 1, `pc_redirect`/flush/bubble 0, `pc_redirect_addr`=`pend_addr`.
- **RUN, evaluated in priority order:**
  1. `dmem_stall`: all five writes 0. Next state DWAIT. `ex_flush` is ignored this cycle because EX holds and re-presents it.
  2. `ex_flush`:
     - Drive `pc_redirect`=1, `pc_redirect_addr`=`ex_next_pc`, `ifid_flush`=1, `idex_bubble`=1.
     - If `imem_stall` is also high: `pc_write`=0, latch `pend_addr`←`ex_next_pc`, `pend_valid`←1, next state IWAIT.
  3. `lu`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Stays in RUN. The hazard clears on its own after one bubble.
  4. `imem_stall`: `pc_write`=0, `ifid_flush`=1. Stays in RUN.
- **DWAIT:**
  - While `dmem_done`=0: all writes 0.
  - On the `dmem_done` cycle: all writes 1, next state RUN.
  - `dmem_done` takes precedence over a simultaneous `dmem_stall`.
- **IWAIT:**
  - Drive `pc_write`=0, `ifid_flush`=1; downstream writes stay 1.
  - A new `ex_flush` overwrites `pend_addr`. This cannot arise architecturally because the bubbled IF/ID contents cannot flush, but it must be handled.
  - On `imem_done`: `pc_write`=1, `pc_redirect`=1 with `pend_addr`; clear `pend_valid`; next state RUN.
  - `dmem_stall` in IWAIT: all writes 0 that cycle, stay in IWAIT, `pend` retained.
- **Halt:** `memwb_halt` AND `memwb_write` → next state HALTED. This has priority over every other transition.
- **HALTED:** all writes 0, `halted`=1. Only `rst` exits.
- **`stall_count`:** +1 every cycle where `pc_write`=0 and state≠HALTED. Saturates at all-ones and never wraps.

## Timing
- **Reset:**
  - When `rst` is sampled high: state←RUN, `pend_valid`←0, `pend_addr`←0, `stall_count`←0.
  - While `rst` is high, the combinational outputs are forced to: writes 0, flush/bubble/redirect 0, `halted`=0.
  - Reset asserted mid-DWAIT or mid-IWAIT discards the pending redirect.
- **Output timing:** all outputs except `stall_count` are combinational from the current state and inputs, with zero-cycle latency. `stall_count` reflects cycles up to the previous edge.
- **Redirect:** the PC updates at the edge ending the `ex_flush` cycle. The two younger instructions (IF/ID, ID/EX) are squashed: exactly two bubbles.
- **Load-use:** exactly one bubble; the stalled instruction issues to EX in the next cycle.
- **Data-memory stall:** a stall lasting N cycles before `dmem_done` freezes the pipeline for N cycles. `stall_count` increases by N.

## Test plan
- **Load-use:** LD r1 in EX, ADD r2,r1,r3 in ID → 1 cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Next cycle all enables 1. `stall_count`=1.
- **Branch flush:** `ex_flush`=1, `ex_next_pc`=0x0040 → `pc_redirect`=1, `pc_redirect_addr`=0x0040, `ifid_flush`=`idex_bubble`=1, same cycle.
- **Flush during fetch stall:** `ex_flush`+`imem_stall` with target 0x0100, then `imem_done` 3 cycles later → redirect to 0x0100 on the `imem_done` cycle. `stall_count`=4 (the flush cycle plus the 3 waiting cycles).
- **Data-memory stall precedence:** `dmem_stall` 5 cycles with a concurrent `lu`/`ex_flush` → all writes 0 for 5 cycles. The `dmem_done` cycle advances. The flush is then honoured.
- **Halt:** HALT reaches MEM/WB → `halted`=1 the following cycle, all writes 0. `rst` pulse → `halted`=0, `stall_count`=0.
- **Saturation:** with `STALL_CNT_W`=4, hold `imem_stall` for 20 cycles → `stall_count`=0xF, no wrap.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller for the five-stage WISC core: pipeline/PC enables,
// bubbles and flushes for load-use, EX redirect, memory stalls and halt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal issue; hazards resolved combinationally
// S_DWAIT  | whole pipeline frozen until data memory completes
// S_IWAIT  | fetch outstanding while a redirect target is held in pend
// S_HALTED | HALT retired through MEM/WB; only rst leaves
module pipe_seq_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            ifid_instr,
   input  logic                   idex_mem_read,
   input  logic [2:0]             idex_dst_reg,
   input  logic                   ex_flush,
   input  logic [15:0]            ex_next_pc,
   input  logic                   imem_stall,
   input  logic                   imem_done,
   input  logic                   dmem_stall,
   input  logic                   dmem_done,
   input  logic                   memwb_halt,
   output logic                   pc_write,
   output logic                   pc_redirect,
   output logic [15:0]            pc_redirect_addr,
   output logic                   ifid_write,
   output logic                   idex_write,
   output logic                   exmem_write,
   output logic                   memwb_write,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {S_RUN, S_DWAIT, S_IWAIT, S_HALTED} state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_pend_valid, w_pend_valid_nxt;
   logic [15:0]            r_pend_addr, w_pend_addr_nxt;
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic [4:0]  w_opcode;
   logic        w_rs_used, w_rt_used, w_lu;
   logic [15:0] w_iwait_target;
   logic        w_unused_instr_bits;

   assign w_opcode            = ifid_instr[15:11];
   assign w_unused_instr_bits = ^ifid_instr[4:0];

   always_comb begin
      w_rs_used = 1'b1;
      case (w_opcode)
         5'b00000, 5'b00001, 5'b00010, 5'b00011,
         5'b00100, 5'b00110, 5'b11000: w_rs_used = 1'b0;
         default:                      w_rs_used = 1'b1;
      endcase
      w_rt_used = (w_opcode == 5'b10000) || (w_opcode == 5'b10011) ||
                  (w_opcode == 5'b11010) || (w_opcode == 5'b11011) ||
                  (w_opcode[4:2] == 3'b111);
   end

   assign w_lu = idex_mem_read &&
                 ((w_rs_used && (ifid_instr[10:8] == idex_dst_reg)) ||
                  (w_rt_used && (ifid_instr[7:5] == idex_dst_reg)));

   // A late flush while waiting replaces the held target, even on the completion cycle.
   assign w_iwait_target = ex_flush ? ex_next_pc : r_pend_addr;

   always_comb begin
      w_state_nxt      = r_state;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_addr_nxt  = r_pend_addr;
      pc_write         = 1'b1;
      ifid_write       = 1'b1;
      idex_write       = 1'b1;
      exmem_write      = 1'b1;
      memwb_write      = 1'b1;
      pc_redirect      = 1'b0;
      pc_redirect_addr = r_pend_addr;
      ifid_flush       = 1'b0;
      idex_bubble      = 1'b0;
      halted           = 1'b0;

      case (r_state)
         S_RUN: begin
            if (dmem_stall) begin
               {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b0;
               w_state_nxt = S_DWAIT;
            end else if (ex_flush) begin
               pc_redirect      = 1'b1;
               pc_redirect_addr = ex_next_pc;
               ifid_flush       = 1'b1;
               idex_bubble      = 1'b1;
               if (imem_stall) begin
                  pc_write         = 1'b0;
                  w_pend_addr_nxt  = ex_next_pc;
                  w_pend_valid_nxt = 1'b1;
                  w_state_nxt      = S_IWAIT;
               end
            end else if (w_lu) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else if (imem_stall) begin
               pc_write   = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         S_DWAIT: begin
            if (dmem_done) begin
               w_state_nxt = S_RUN;
            end else begin
               {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b0;
            end
         end
         S_IWAIT: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            if (dmem_stall) begin
               {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b0;
            end else begin
               if (ex_flush) begin
                  w_pend_addr_nxt = ex_next_pc;
                  idex_bubble     = 1'b1;
               end
               if (imem_done) begin
                  pc_write         = 1'b1;
                  pc_redirect      = r_pend_valid | ex_flush;
                  pc_redirect_addr = w_iwait_target;
                  w_pend_valid_nxt = 1'b0;
                  w_state_nxt      = S_RUN;
               end
            end
         end
         S_HALTED: begin
            {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b0;
            halted = 1'b1;
         end
         default: w_state_nxt = S_RUN;
      endcase

      if (memwb_halt && memwb_write) begin
         w_state_nxt = S_HALTED;
      end

      if (rst) begin
         {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b0;
         pc_redirect = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_RUN;
         r_pend_valid  <= 1'b0;
         r_pend_addr   <= 16'h0000;
         r_stall_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_addr  <= w_pend_addr_nxt;
         if (!pc_write && (r_state != S_HALTED) && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
         end
      end
   end

   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: hazards, redirects, memory stalls, halt and
// counter saturation (second instance with a 4-bit counter).
module tb_pipe_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ifid_instr;
   logic        idex_mem_read;
   logic [2:0]  idex_dst_reg;
   logic        ex_flush;
   logic [15:0] ex_next_pc;
   logic        imem_stall, imem_done, dmem_stall, dmem_done, memwb_halt;

   logic        pc_write, pc_redirect, ifid_write, idex_write, exmem_write, memwb_write;
   logic        ifid_flush, idex_bubble, halted;
   logic [15:0] pc_redirect_addr;
   logic [15:0] stall_count;

   logic        s_pc_write, s_pc_redirect, s_ifid_write, s_idex_write, s_exmem_write;
   logic        s_memwb_write, s_ifid_flush, s_idex_bubble, s_halted;
   logic [15:0] s_pc_redirect_addr;
   logic [3:0]  s_stall_count;

   logic [4:0]  w_wr;
   assign w_wr = {pc_write, ifid_write, idex_write, exmem_write, memwb_write};

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   pipe_seq_ctrl #(.STALL_CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read),
      .idex_dst_reg(idex_dst_reg), .ex_flush(ex_flush), .ex_next_pc(ex_next_pc),
      .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall),
      .dmem_done(dmem_done), .memwb_halt(memwb_halt), .pc_write(pc_write),
      .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
      .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
      .memwb_write(memwb_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .halted(halted), .stall_count(stall_count)
   );

   pipe_seq_ctrl #(.STALL_CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read),
      .idex_dst_reg(idex_dst_reg), .ex_flush(ex_flush), .ex_next_pc(ex_next_pc),
      .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall),
      .dmem_done(dmem_done), .memwb_halt(memwb_halt), .pc_write(s_pc_write),
      .pc_redirect(s_pc_redirect), .pc_redirect_addr(s_pc_redirect_addr),
      .ifid_write(s_ifid_write), .idex_write(s_idex_write), .exmem_write(s_exmem_write),
      .memwb_write(s_memwb_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
      .halted(s_halted), .stall_count(s_stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ifid_instr    = 16'h0000;
      idex_mem_read = 1'b0;
      idex_dst_reg  = 3'd0;
      ex_flush      = 1'b0;
      ex_next_pc    = 16'h0000;
      imem_stall    = 1'b0;
      imem_done     = 1'b0;
      dmem_stall    = 1'b0;
      dmem_done     = 1'b0;
      memwb_halt    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      // reset state
      samp();
      chk("rst_writes", {27'd0, w_wr}, 32'h00);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
      rst = 1'b0;
      samp();
      chk("post_rst_writes", {27'd0, w_wr}, 32'h1F);
      chk("post_rst_count", {16'd0, stall_count}, 32'd0);
      tick();

      // load-use via rs: LD r1 in EX, ADD r2,r1,r3 in ID
      idex_mem_read = 1'b1; idex_dst_reg = 3'd1; ifid_instr = 16'hD968;
      samp();
      chk("lu_writes", {27'd0, w_wr}, 32'h07);
      chk("lu_bubble", {31'd0, idex_bubble}, 32'd1);
      tick();
      idle();
      samp();
      chk("lu_after_writes", {27'd0, w_wr}, 32'h1F);
      chk("lu_after_bubble", {31'd0, idex_bubble}, 32'd0);
      chk("lu_count", {16'd0, stall_count}, 32'd1);
      tick();

      // load-use via rt (ADD r2,r3,r1)
      idex_mem_read = 1'b1; idex_dst_reg = 3'd1; ifid_instr = 16'hDB28;
      samp();
      chk("lu_rt_pcw", {31'd0, pc_write}, 32'd0);
      tick();
      // opcode 00000 ignores rs field
      ifid_instr = 16'h0100;
      samp();
      chk("lu_rs_excl_pcw", {31'd0, pc_write}, 32'd1);
      tick();
      // opcode 01000 ignores rt field
      ifid_instr = 16'h4020;
      samp();
      chk("lu_rt_excl_pcw", {31'd0, pc_write}, 32'd1);
      tick();
      // opcode 111xx uses rt
      ifid_instr = 16'hE020;
      samp();
      chk("lu_111xx_pcw", {31'd0, pc_write}, 32'd0);
      tick();
      idle();
      samp();
      chk("lu_count3", {16'd0, stall_count}, 32'd3);
      tick();

      // branch flush
      ex_flush = 1'b1; ex_next_pc = 16'h0040;
      samp();
      chk("br_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("br_addr", {16'd0, pc_redirect_addr}, 32'h0040);
      chk("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
      chk("br_bubble", {31'd0, idex_bubble}, 32'd1);
      chk("br_pcw", {31'd0, pc_write}, 32'd1);
      tick();

      // flush during fetch stall
      do_reset();
      ex_flush = 1'b1; imem_stall = 1'b1; ex_next_pc = 16'h0100;
      samp();
      chk("fs_pcw", {31'd0, pc_write}, 32'd0);
      chk("fs_redirect", {31'd0, pc_redirect}, 32'd1);
      chk("fs_addr", {16'd0, pc_redirect_addr}, 32'h0100);
      tick();
      ex_flush = 1'b0; ex_next_pc = 16'h0BAD;
      for (int i = 0; i < 3; i++) begin
         samp();
         chk("fs_wait_pcw", {31'd0, pc_write}, 32'd0);
         chk("fs_wait_flush", {31'd0, ifid_flush}, 32'd1);
         chk("fs_wait_idexw", {31'd0, idex_write}, 32'd1);
         chk("fs_wait_redir", {31'd0, pc_redirect}, 32'd0);
         tick();
      end
      imem_stall = 1'b0; imem_done = 1'b1;
      samp();
      chk("fs_done_pcw", {31'd0, pc_write}, 32'd1);
      chk("fs_done_redir", {31'd0, pc_redirect}, 32'd1);
      chk("fs_done_addr", {16'd0, pc_redirect_addr}, 32'h0100);
      tick();
      idle();
      samp();
      chk("fs_count", {16'd0, stall_count}, 32'd4);
      chk("fs_after_redir", {31'd0, pc_redirect}, 32'd0);
      tick();

      // data-memory stall precedence over flush and load-use
      do_reset();
      dmem_stall = 1'b1; ex_flush = 1'b1; ex_next_pc = 16'h0200;
      idex_mem_read = 1'b1; idex_dst_reg = 3'd1; ifid_instr = 16'hD968;
      for (int i = 0; i < 5; i++) begin
         samp();
         chk("ds_writes", {27'd0, w_wr}, 32'h00);
         chk("ds_redir", {31'd0, pc_redirect}, 32'd0);
         tick();
      end
      dmem_done = 1'b1;
      samp();
      chk("ds_done_writes", {27'd0, w_wr}, 32'h1F);
      tick();
      dmem_stall = 1'b0; dmem_done = 1'b0; idex_mem_read = 1'b0;
      samp();
      chk("ds_flush_redir", {31'd0, pc_redirect}, 32'd1);
      chk("ds_flush_addr", {16'd0, pc_redirect_addr}, 32'h0200);
      chk("ds_count", {16'd0, stall_count}, 32'd5);
      tick();

      // halt
      do_reset();
      imem_stall = 1'b1;
      tick();
      imem_stall = 1'b0; memwb_halt = 1'b1;
      samp();
      chk("ht_pre_halted", {31'd0, halted}, 32'd0);
      tick();
      memwb_halt = 1'b0; imem_stall = 1'b1;
      samp();
      chk("ht_halted", {31'd0, halted}, 32'd1);
      chk("ht_writes", {27'd0, w_wr}, 32'h00);
      tick();
      samp();
      chk("ht_count_frozen", {16'd0, stall_count}, 32'd1);
      idle();
      rst = 1'b1;
      samp();
      chk("ht_rst_halted", {31'd0, halted}, 32'd0);
      tick();
      rst = 1'b0;
      samp();
      chk("ht_post_halted", {31'd0, halted}, 32'd0);
      chk("ht_post_count", {16'd0, stall_count}, 32'd0);
      tick();

      // reset mid-IWAIT drops the held redirect
      do_reset();
      ex_flush = 1'b1; imem_stall = 1'b1; ex_next_pc = 16'h0300;
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_done = 1'b1;
      samp();
      chk("iw_rst_redir", {31'd0, pc_redirect}, 32'd0);
      chk("iw_rst_pcw", {31'd0, pc_write}, 32'd1);
      tick();

      // counter saturation
      do_reset();
      imem_stall = 1'b1;
      repeat (20) tick();
      samp();
      chk("sat_cnt4", {28'd0, s_stall_count}, 32'hF);
      chk("sat_cnt16", {16'd0, stall_count}, 32'd20);
      idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
